vdp_cpu_bridge: RTL and testbench



---
 rtl/vdp_cpu_bridge.sv | 171 +++++++++++++++++
 tb/tb_vdp_cpu_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_bridge.sv
// rtl/vdp_cpu_bridge.sv - V9958 host-bus front end: strobe sync/glitch filter, one REQ/WRT per CPU access
// Optional feature macro: CPU_BRIDGE_RDLATCH_EN (freeze cd_o at the read ISSUE cycle).
module vdp_cpu_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_n_i,
  input  logic        csw_n_i,
  input  logic [1:0]  mode_i,
  input  logic [0:7]  cd_i,
  input  logic [7:0]  vdp_dbi,
  output logic        cpu_req,
  output logic        cpu_wrt,
  output logic [15:0] cpu_adr,
  output logic [7:0]  cpu_dbo,
  output logic [7:0]  cd_o,
  output logic        cd_oe,
  output logic        err_both
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  localparam logic [3:0] ARM_INIT = 4'(SYNC_STAGES + FILTER_LEN + 1);

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [1:0]             mode_sync [SYNC_STAGES];
  logic [7:0]             cd_sync   [SYNC_STAGES];

  logic [1:0] strb_s;
  logic [1:0] f_n;
  logic [1:0] flt_cnt [2];

  state_t     state;
  state_t     state_nx;
  logic [1:0] pair;
  logic       take_pair;
  logic       take_data;
  logic       err_done;
  logic [3:0] arm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sync <= '1;
      wr_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        mode_sync[i] <= '0;
        cd_sync[i]   <= '0;
      end
    end else begin
      rd_sync      <= {rd_sync[SYNC_STAGES-2:0], csr_n_i};
      wr_sync      <= {wr_sync[SYNC_STAGES-2:0], csw_n_i};
      mode_sync[0] <= mode_i;
      cd_sync[0]   <= cd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mode_sync[i] <= mode_sync[i-1];
        cd_sync[i]   <= cd_sync[i-1];
      end
    end
  end

  // Bit 1 is the read strobe, bit 0 the write strobe throughout.
  assign strb_s = {rd_sync[SYNC_STAGES-1], wr_sync[SYNC_STAGES-1]};

  // The counter tracks consecutive samples disagreeing with the filtered level;
  // the current sample plus FILTER_LEN-1 earlier ones must all disagree to flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_n        <= 2'b11;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (strb_s[i] == f_n[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == 2'(FILTER_LEN - 1)) begin
          f_n[i]     <= strb_s[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pair     <= 2'b11;
      cpu_adr  <= '0;
      cpu_dbo  <= '0;
      err_done <= 1'b0;
      arm_cnt  <= ARM_INIT;
    end else begin
      state <= state_nx;
      if (take_pair) pair <= f_n;
      if (take_data) begin
        cpu_adr <= {14'b0, mode_sync[SYNC_STAGES-1]};
        cpu_dbo <= rev8(cd_sync[SYNC_STAGES-1]);
      end
      if (f_n != 2'b00)  err_done <= 1'b0;
      else if (err_both) err_done <= 1'b1;
      if (arm_cnt != 4'd0) arm_cnt <= arm_cnt - 4'd1;
    end
  end

  // While arm_cnt runs, a strobe already low at reset release reaches the
  // filter output; it is parked in HOLD instead of being issued.
  always_comb begin
    state_nx  = state;
    take_pair = 1'b0;
    take_data = 1'b0;
    cpu_req   = 1'b0;
    cpu_wrt   = 1'b0;
    err_both  = 1'b0;
    case (state)
      IDLE: begin
        if (f_n != 2'b11) begin
          if (arm_cnt != 4'd0) begin
            take_pair = 1'b1;
            state_nx  = HOLD;
          end else if (f_n == 2'b00) begin
            err_both = ~err_done;
          end else begin
            take_pair = 1'b1;
            take_data = 1'b1;
            state_nx  = ISSUE;
          end
        end
      end
      ISSUE: begin
        cpu_req  = 1'b1;
        cpu_wrt  = ~pair[0];
        state_nx = HOLD;
      end
      HOLD: begin
        if (f_n != pair) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cd_o <= '0;
`ifdef CPU_BRIDGE_RDLATCH_EN
    end else if (state == ISSUE && pair == 2'b01) begin
      cd_o <= rev8(vdp_dbi);
    end
`else
    end else begin
      cd_o <= rev8(vdp_dbi);
    end
`endif
  end

  assign cd_oe = ~csr_n_i & csw_n_i;

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// tb/tb_vdp_cpu_bridge.sv - scoreboard bench for vdp_cpu_bridge
module tb_vdp_cpu_bridge;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_n_i;
  logic        csw_n_i;
  logic [1:0]  mode_i;
  logic [0:7]  cd_i;
  logic [7:0]  vdp_dbi;
  logic        cpu_req;
  logic        cpu_wrt;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dbo;
  logic [7:0]  cd_o;
  logic        cd_oe;
  logic        err_both;

  typedef struct {
    int          cyc;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vdp_cpu_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .csr_n_i  (csr_n_i),
    .csw_n_i  (csw_n_i),
    .mode_i   (mode_i),
    .cd_i     (cd_i),
    .vdp_dbi  (vdp_dbi),
    .cpu_req  (cpu_req),
    .cpu_wrt  (cpu_wrt),
    .cpu_adr  (cpu_adr),
    .cpu_dbo  (cpu_dbo),
    .cd_o     (cd_o),
    .cd_oe    (cd_oe),
    .err_both (err_both)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_req(input int at, input logic wrt, input logic [15:0] adr, input logic [7:0] dbo);
    exp_t e;
    e.cyc = at;
    e.wrt = wrt;
    e.adr = adr;
    e.dbo = dbo;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cpu_req / err_both pulse is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_req) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_req: cpu_req=1 at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("req_cycle", cyc, e.cyc);
          chk("req_wrt", {31'b0, cpu_wrt}, {31'b0, e.wrt});
          chk("req_adr", {16'b0, cpu_adr}, {16'b0, e.adr});
          chk("req_dbo", {24'b0, cpu_dbo}, {24'b0, e.dbo});
        end
      end
      if (err_both) begin
        if (err_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_err: err_both=1 at cycle %0d, expected none", cyc);
        end else begin
          chk("err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset   = 1'b1;
    csr_n_i = 1'b1;
    csw_n_i = 1'b1;
    mode_i  = 2'b00;
    cd_i    = 8'h00;
    vdp_dbi = 8'h00;
    idle(3);
    chk("rst_req", {31'b0, cpu_req}, 0);
    chk("rst_adr", {16'b0, cpu_adr}, 0);
    chk("rst_cd_o", {24'b0, cd_o}, 0);
    reset = 1'b0;
    idle(10);

    // Write, mode 1, A5, long strobe
    mode_i = 2'b01; cd_i = 8'hA5;
    idle(3);
    csw_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b1, 16'h0001, 8'hA5);
    idle(20);
    csw_n_i = 1'b1;
    idle(8);

    // Write, mode 2, 01 -> 80
    mode_i = 2'b10; cd_i = 8'h01;
    idle(3);
    csw_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b1, 16'h0002, 8'h80);
    idle(8);
    chk("dbo_hold", {24'b0, cpu_dbo}, 32'h80);
    csw_n_i = 1'b1;
    idle(8);

    // Read with vdp_dbi changing after REQ
    mode_i = 2'b11; vdp_dbi = 8'h3C;
    idle(3);
    csr_n_i = 1'b0; c = cyc;
    #1 chk("cd_oe_read", {31'b0, cd_oe}, 1);
    push_req(c + LAT, 1'b0, 16'h0003, 8'h80);
    idle(6);
    vdp_dbi = 8'hFF;
    idle(3);
`ifdef CPU_BRIDGE_RDLATCH_EN
    chk("cd_o_hold_a", {24'b0, cd_o}, 32'h3C);
`else
    chk("cd_o_hold_a", {24'b0, cd_o}, 32'hFF);
`endif
    vdp_dbi = 8'h12;
    idle(2);
`ifdef CPU_BRIDGE_RDLATCH_EN
    chk("cd_o_hold_b", {24'b0, cd_o}, 32'h3C);
`else
    chk("cd_o_hold_b", {24'b0, cd_o}, 32'h48);
`endif
    idle(9);
    csr_n_i = 1'b1;
    #1 chk("cd_oe_off", {31'b0, cd_oe}, 0);
    idle(8);

    // Glitches: 1 clk rejected, 2 clk accepted once
    mode_i = 2'b00; cd_i = 8'h0F;
    idle(3);
    csw_n_i = 1'b0;
    idle(1);
    csw_n_i = 1'b1;
    idle(10);
    csw_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b1, 16'h0000, 8'hF0);
    idle(2);
    csw_n_i = 1'b1;
    idle(10);

    // Both strobes together, then a normal read
    csr_n_i = 1'b0; csw_n_i = 1'b0; c = cyc;
    #1 chk("cd_oe_both", {31'b0, cd_oe}, 0);
    err_q.push_back(c + LAT - 1);
    idle(10);
    csr_n_i = 1'b1; csw_n_i = 1'b1;
    idle(8);
    mode_i = 2'b01;
    idle(3);
    csr_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b0, 16'h0001, 8'hF0);
    idle(8);
    csr_n_i = 1'b1;
    idle(8);

    // Back-to-back read then write without a release gap
    mode_i = 2'b10; cd_i = 8'h03;
    idle(3);
    csr_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b0, 16'h0002, 8'hC0);
    idle(10);
    csr_n_i = 1'b1; csw_n_i = 1'b0; c = cyc;
    push_req(c + LAT + 1, 1'b1, 16'h0002, 8'hC0);
    idle(10);
    csw_n_i = 1'b1;
    idle(8);

    // Reset one cycle before ISSUE with the write strobe held low
    mode_i = 2'b01; cd_i = 8'h80;
    idle(3);
    csw_n_i = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(1);
    chk("mid_rst_req", {31'b0, cpu_req}, 0);
    chk("mid_rst_wrt", {31'b0, cpu_wrt}, 0);
    chk("mid_rst_adr", {16'b0, cpu_adr}, 0);
    chk("mid_rst_dbo", {24'b0, cpu_dbo}, 0);
    chk("mid_rst_cd_o", {24'b0, cd_o}, 0);
    chk("mid_rst_err", {31'b0, err_both}, 0);
    idle(2);
    reset = 1'b0;
    idle(15);
    csw_n_i = 1'b1;
    idle(6);
    csw_n_i = 1'b0; c = cyc;
    push_req(c + LAT, 1'b1, 16'h0001, 8'h01);
    idle(8);
    csw_n_i = 1'b1;
    idle(20);

    chk("req_queue_drained", exp_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
